// File: rtl/pulse_pacer.sv
// Paces single-cycle event strobes into pulses spaced exactly GAP cycles apart,
// queueing the backlog in a saturating counter and flagging dropped events.
module pulse_pacer #(
  parameter int GAP   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  output logic             busy
);

  localparam int TW = $clog2(GAP);
  localparam logic [TW-1:0]    RELOAD = TW'(GAP - 1);
  localparam logic [CNT_W-1:0] MAX    = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [CNT_W-1:0] pend_nx;
  logic             issue, drop;

  always_comb begin
    issue = ((state == IDLE) || (state == HOLD && timer == '0)) &&
            ((pending != '0) || ev_in);
    // A full backlog still accepts an event when an issue frees a slot that cycle.
    drop  = ev_in && !issue && (pending == MAX);

    pend_nx = pending;
    if (ev_in && !issue && !drop)
      pend_nx = pending + 1'b1;
    else if (!ev_in && issue)
      pend_nx = pending - 1'b1;

    // The timer runs through ISSUE as well so the next ISSUE lands exactly GAP later.
    timer_nx = '0;
    if (issue)
      timer_nx = RELOAD;
    else if (timer != '0)
      timer_nx = timer - 1'b1;

    state_nx = state;
    if (issue)
      state_nx = ISSUE;
    else begin
      case (state)
        ISSUE:   state_nx = HOLD;
        HOLD:    state_nx = (timer == '0) ? IDLE : HOLD;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pending   <= '0;
      pulse_out <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      pending   <= pend_nx;
      pulse_out <= issue;
      ovf       <= drop | (ovf & ~ovf_clr);
      busy      <= (pend_nx != '0) || (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: a timeline model predicts pulse cycles,
// backlog, busy and ovf; a second instance drives a toggle synchronizer at 4:1.
module tb_pulse_pacer;

  localparam int GAP = 4, CNT_W = 2, MAXP = 3, GAP2 = 9;

  logic clk = 1'b0, clk_slow = 1'b0;
  logic rst, ev_in, ovf_clr, ev2;
  logic pulse_out, ovf, busy;
  logic [CNT_W-1:0] pending;
  logic pulse2, ovf2, busy2;
  logic [3:0] pending2;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit armed = 0;
  int exp_q[$];
  int sched[$];
  bit exp_ovf = 0;

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 clk_slow = ~clk_slow;
  end

  pulse_pacer #(.GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ev_in(ev_in), .ovf_clr(ovf_clr),
    .pulse_out(pulse_out), .pending(pending), .ovf(ovf), .busy(busy)
  );

  pulse_pacer #(.GAP(GAP2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .ev_in(ev2), .ovf_clr(1'b0),
    .pulse_out(pulse2), .pending(pending2), .ovf(ovf2), .busy(busy2)
  );

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(bit e, bit c, bit r, bit e2);
    ev_in = e; ovf_clr = c; rst = r; ev2 = e2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted event is given a pulse cycle max(c+1, last+GAP).
  always @(negedge clk) begin : mon
    int  pend_e, front, lastall, p;
    bit  busy_e, hit, dropped;
    if (armed) begin
      front = (exp_q.size() != 0) ? exp_q[0] : -1;
      check("pulse", int'(pulse_out), int'(front == cyc));
      if (front == cyc) void'(exp_q.pop_front());
      pend_e = 0; busy_e = 0; hit = 0; lastall = -1000;
      foreach (sched[i]) begin
        if (sched[i] > cyc) pend_e++;
        if (sched[i] <= cyc && cyc < sched[i] + GAP) busy_e = 1;
        if (sched[i] == cyc + 1) hit = 1;
        if (sched[i] > lastall) lastall = sched[i];
      end
      if (pend_e != 0) busy_e = 1;
      check("pending", int'(pending), pend_e);
      check("busy", int'(busy), int'(busy_e));
      check("ovf", int'(ovf), int'(exp_ovf));
      if (rst) begin
        sched.delete(); exp_q.delete(); exp_ovf = 0;
      end else begin
        dropped = 0;
        if (ev_in) begin
          if (pend_e == MAXP && !hit) dropped = 1;
          else begin
            p = (cyc + 1 > lastall + GAP) ? cyc + 1 : lastall + GAP;
            sched.push_back(p);
            exp_q.push_back(p);
          end
        end
        exp_ovf = dropped | (exp_ovf & !ovf_clr);
      end
      while (sched.size() > 1 && sched[0] < cyc - GAP) void'(sched.pop_front());
    end
  end

  // Toggle synchronizer into the slow domain, fed by the second instance.
  bit tog, s1, s2, s3, sp_prev;
  int n_p2, n_s, n_dbl;
  always @(posedge clk) if (pulse2) begin tog <= ~tog; n_p2 <= n_p2 + 1; end
  always @(posedge clk_slow) begin
    s1 <= tog; s2 <= s1; s3 <= s2;
    sp_prev <= s2 ^ s3;
    if (s2 ^ s3) begin
      n_s <= n_s + 1;
      if (sp_prev) n_dbl <= n_dbl + 1;
    end
  end

  initial begin
    int sent, b;
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    rst = 0;
    armed = 1;
    // single event, burst of 3, saturation burst of 6
    drive(1, 0, 0, 0); idle(10);
    repeat (3) drive(1, 0, 0, 0); idle(12);
    repeat (6) drive(1, 0, 0, 0); idle(20);
    // clear with no drop, then a clear coinciding with a drop
    drive(0, 1, 0, 0); idle(2);
    repeat (5) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0); idle(20);
    drive(0, 1, 0, 0); idle(2);
    // reset mid-backlog with ev_in high, then a fresh event
    repeat (5) drive(1, 0, 0, 0);
    drive(1, 0, 1, 0); idle(2);
    drive(1, 0, 0, 0); idle(10);
    repeat (150) drive($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 99) == 0, 0);
    idle(30);
    check("queue_empty", exp_q.size(), 0);
    // end-to-end through the synchronizer
    sent = 0;
    while (sent < 20) begin
      b = (sent == 0) ? 2 : ((20 - sent >= 2) ? $urandom_range(1, 2) : 1);
      repeat (b) drive(0, 0, 0, 1);
      sent += b;
      idle($urandom_range(20, 30));
    end
    idle(60);
    check("fast_pulses", n_p2, 20);
    check("slow_pulses", n_s, 20);
    check("slow_double", n_dbl, 0);
    check("ovf2", int'(ovf2), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
